// File: rtl/measure_centroid.sv
// Per-frame object locator: accumulates object-pixel count, coordinate sums and
// bounding box over a raster stream, then divides for the centroid at frame end.
module measure_centroid #(
    parameter int unsigned COLOR_WIDTH  = 10,
    parameter int unsigned FRAME_WIDTH  = 640,
    parameter int unsigned FRAME_HEIGHT = 480,
    parameter int unsigned COORD_WIDTH  = 11,
    parameter int unsigned SUM_WIDTH    = 27,
    parameter int unsigned COUNT_WIDTH  = 19,
    parameter int unsigned MIN_PIXELS   = 16
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   pixel_valid,
    input  logic                   sof,
    input  logic [COLOR_WIDTH-1:0] delta_frame,
    input  logic [COLOR_WIDTH-1:0] threshold,
    output logic [COORD_WIDTH-1:0] x_position,
    output logic [COORD_WIDTH-1:0] y_position,
    output logic [COORD_WIDTH-1:0] x_min,
    output logic [COORD_WIDTH-1:0] x_max,
    output logic [COORD_WIDTH-1:0] y_min,
    output logic [COORD_WIDTH-1:0] y_max,
    output logic [COUNT_WIDTH-1:0] pixel_count,
    output logic                   object_found,
    output logic                   valid_position,
    output logic                   busy,
    output logic                   overrun
);
    localparam int unsigned X_LAST    = FRAME_WIDTH - 1;
    localparam int unsigned Y_LAST    = FRAME_HEIGHT - 1;
    localparam int unsigned ITER_W    = $clog2(SUM_WIDTH + 1);
    localparam int unsigned ITER_LAST = SUM_WIDTH - 1;

    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [COORD_WIDTH-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [SUM_WIDTH-1:0]   xsum_q, xsum_d, ysum_q, ysum_d;
    logic [COORD_WIDTH-1:0] bxmin_q, bxmin_d, bxmax_q, bxmax_d, bymin_q, bymin_d, bymax_q, bymax_d;
    logic [COUNT_WIDTH-1:0] div_q, div_d;
    logic [SUM_WIDTH-1:0]   xquo_q, xquo_d, yquo_q, yquo_d;
    logic [COUNT_WIDTH-1:0] xrem_q, xrem_d, yrem_q, yrem_d;
    logic [COORD_WIDTH-1:0] sxmin_q, sxmin_d, sxmax_q, sxmax_d, symin_q, symin_d, symax_q, symax_d;
    logic [ITER_W-1:0]      iter_q, iter_d;
    logic [COORD_WIDTH-1:0] xpos_q, xpos_d, ypos_q, ypos_d;
    logic [COORD_WIDTH-1:0] oxmin_q, oxmin_d, oxmax_q, oxmax_d, oymin_q, oymin_d, oymax_q, oymax_d;
    logic [COUNT_WIDTH-1:0] pcnt_q, pcnt_d;
    logic                   found_q, found_d, valid_q, valid_d, busy_q, busy_d, ovr_q, ovr_d;

    // One restoring-division step: returns {remainder, shifted quotient}
    function automatic logic [COUNT_WIDTH+SUM_WIDTH-1:0] div_step(
        input logic [SUM_WIDTH-1:0]   quo,
        input logic [COUNT_WIDTH-1:0] rem,
        input logic [COUNT_WIDTH-1:0] dvs
    );
        logic [COUNT_WIDTH:0] sh;
        logic                 qb;
        sh = {rem, quo[SUM_WIDTH-1]};
        qb = 1'b0;
        if (sh >= {1'b0, dvs}) begin
            sh = sh - {1'b0, dvs};
            qb = 1'b1;
        end
        return {sh[COUNT_WIDTH-1:0], quo[SUM_WIDTH-2:0], qb};
    endfunction

    logic [COORD_WIDTH-1:0] cur_x, cur_y;
    logic [COUNT_WIDTH-1:0] cnt_n;
    logic [SUM_WIDTH-1:0]   xsum_n, ysum_n;
    logic [COORD_WIDTH-1:0] bxmin_n, bxmax_n, bymin_n, bymax_n;
    logic                   is_obj, first_obj, frame_end;

    always_comb begin
        state_d = state_q;
        x_cnt_d = x_cnt_q;   y_cnt_d = y_cnt_q;
        cnt_d   = cnt_q;     xsum_d  = xsum_q;    ysum_d  = ysum_q;
        bxmin_d = bxmin_q;   bxmax_d = bxmax_q;   bymin_d = bymin_q;   bymax_d = bymax_q;
        div_d   = div_q;     xquo_d  = xquo_q;    yquo_d  = yquo_q;
        xrem_d  = xrem_q;    yrem_d  = yrem_q;    iter_d  = iter_q;
        sxmin_d = sxmin_q;   sxmax_d = sxmax_q;   symin_d = symin_q;   symax_d = symax_q;
        xpos_d  = xpos_q;    ypos_d  = ypos_q;
        oxmin_d = oxmin_q;   oxmax_d = oxmax_q;   oymin_d = oymin_q;   oymax_d = oymax_q;
        pcnt_d  = pcnt_q;    found_d = found_q;   valid_d = 1'b0;      ovr_d   = ovr_q;

        // sof forces the pixel to (0,0) and drops the partial frame
        cur_x     = sof ? '0 : x_cnt_q;
        cur_y     = sof ? '0 : y_cnt_q;
        cnt_n     = sof ? '0 : cnt_q;
        xsum_n    = sof ? '0 : xsum_q;
        ysum_n    = sof ? '0 : ysum_q;
        bxmin_n   = bxmin_q; bxmax_n = bxmax_q; bymin_n = bymin_q; bymax_n = bymax_q;
        first_obj = (cnt_n == '0);
        is_obj    = (delta_frame >= threshold);
        frame_end = pixel_valid && (cur_x == COORD_WIDTH'(X_LAST)) && (cur_y == COORD_WIDTH'(Y_LAST));

        if (is_obj) begin
            cnt_n  = cnt_n + COUNT_WIDTH'(1);
            xsum_n = xsum_n + SUM_WIDTH'(cur_x);
            ysum_n = ysum_n + SUM_WIDTH'(cur_y);
            if (first_obj || cur_x < bxmin_n) bxmin_n = cur_x;
            if (first_obj || cur_x > bxmax_n) bxmax_n = cur_x;
            if (first_obj || cur_y < bymin_n) bymin_n = cur_y;
            if (first_obj || cur_y > bymax_n) bymax_n = cur_y;
        end

        if (pixel_valid) begin
            if (cur_x == COORD_WIDTH'(X_LAST)) begin
                x_cnt_d = '0;
                y_cnt_d = (cur_y == COORD_WIDTH'(Y_LAST)) ? '0 : cur_y + COORD_WIDTH'(1);
            end else begin
                x_cnt_d = cur_x + COORD_WIDTH'(1);
                y_cnt_d = cur_y;
            end
            if (frame_end) begin
                cnt_d = '0; xsum_d = '0; ysum_d = '0;
            end else begin
                cnt_d = cnt_n; xsum_d = xsum_n; ysum_d = ysum_n;
            end
            bxmin_d = bxmin_n; bxmax_d = bxmax_n; bymin_d = bymin_n; bymax_d = bymax_n;
        end

        if (frame_end && state_q != S_IDLE) ovr_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (frame_end) begin
                    div_d   = cnt_n;   xquo_d  = xsum_n;  yquo_d  = ysum_n;
                    xrem_d  = '0;      yrem_d  = '0;      iter_d  = '0;
                    sxmin_d = bxmin_n; sxmax_d = bxmax_n; symin_d = bymin_n; symax_d = bymax_n;
                    state_d = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                {xrem_d, xquo_d} = div_step(xquo_q, xrem_q, div_q);
                {yrem_d, yquo_d} = div_step(yquo_q, yrem_q, div_q);
                iter_d = iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(ITER_LAST)) state_d = S_DONE;
            end
            S_DONE: begin
                pcnt_d  = div_q;
                valid_d = 1'b1;
                if (div_q >= COUNT_WIDTH'(MIN_PIXELS)) begin
                    xpos_d  = COORD_WIDTH'(xquo_q);
                    ypos_d  = COORD_WIDTH'(yquo_q);
                    oxmin_d = sxmin_q; oxmax_d = sxmax_q; oymin_d = symin_q; oymax_d = symax_q;
                    found_d = 1'b1;
                end else begin
                    found_d = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            x_cnt_q <= '0; y_cnt_q <= '0; cnt_q <= '0; xsum_q <= '0; ysum_q <= '0;
            bxmin_q <= '0; bxmax_q <= '0; bymin_q <= '0; bymax_q <= '0;
            div_q <= '0; xquo_q <= '0; yquo_q <= '0; xrem_q <= '0; yrem_q <= '0; iter_q <= '0;
            sxmin_q <= '0; sxmax_q <= '0; symin_q <= '0; symax_q <= '0;
            xpos_q <= '0; ypos_q <= '0; oxmin_q <= '0; oxmax_q <= '0; oymin_q <= '0; oymax_q <= '0;
            pcnt_q <= '0; found_q <= 1'b0; valid_q <= 1'b0; busy_q <= 1'b0; ovr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_cnt_q <= x_cnt_d; y_cnt_q <= y_cnt_d; cnt_q <= cnt_d; xsum_q <= xsum_d; ysum_q <= ysum_d;
            bxmin_q <= bxmin_d; bxmax_q <= bxmax_d; bymin_q <= bymin_d; bymax_q <= bymax_d;
            div_q <= div_d; xquo_q <= xquo_d; yquo_q <= yquo_d; xrem_q <= xrem_d; yrem_q <= yrem_d;
            iter_q <= iter_d;
            sxmin_q <= sxmin_d; sxmax_q <= sxmax_d; symin_q <= symin_d; symax_q <= symax_d;
            xpos_q <= xpos_d; ypos_q <= ypos_d;
            oxmin_q <= oxmin_d; oxmax_q <= oxmax_d; oymin_q <= oymin_d; oymax_q <= oymax_d;
            pcnt_q <= pcnt_d; found_q <= found_d; valid_q <= valid_d; busy_q <= busy_d; ovr_q <= ovr_d;
        end
    end

    assign x_position     = xpos_q;
    assign y_position     = ypos_q;
    assign x_min          = oxmin_q;
    assign x_max          = oxmax_q;
    assign y_min          = oymin_q;
    assign y_max          = oymax_q;
    assign pixel_count    = pcnt_q;
    assign object_found   = found_q;
    assign valid_position = valid_q;
    assign busy           = busy_q;
    assign overrun        = ovr_q;
endmodule

// File: tb/tb_measure_centroid.sv
// Scoreboard bench for measure_centroid: a 40x30 frame instance for the main
// scenarios and a 4x4 instance that provokes a divider overrun.
module tb_measure_centroid;
    localparam int FW = 40, FH = 30, LAT = 28;

    logic clk = 1'b0, rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        pv = 1'b0, sof = 1'b0;
    logic [9:0]  dlt = '0, thr = 10'd512;
    logic [10:0] xp, yp, xmn, xmx, ymn, ymx;
    logic [18:0] pc;
    logic        fnd, vld, bsy, ovr;

    logic        pv2 = 1'b0, sof2 = 1'b0;
    logic [9:0]  dlt2 = '0, thr2 = 10'd512;
    logic [10:0] xp2, yp2, xmn2, xmx2, ymn2, ymx2;
    logic [18:0] pc2;
    logic        fnd2, vld2, bsy2, ovr2;

    measure_centroid #(.COLOR_WIDTH(10), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .COORD_WIDTH(11),
                       .SUM_WIDTH(27), .COUNT_WIDTH(19), .MIN_PIXELS(16)) dut (
        .clk(clk), .aresetn(rst_n), .pixel_valid(pv), .sof(sof), .delta_frame(dlt), .threshold(thr),
        .x_position(xp), .y_position(yp), .x_min(xmn), .x_max(xmx), .y_min(ymn), .y_max(ymx),
        .pixel_count(pc), .object_found(fnd), .valid_position(vld), .busy(bsy), .overrun(ovr));

    measure_centroid #(.COLOR_WIDTH(10), .FRAME_WIDTH(4), .FRAME_HEIGHT(4), .COORD_WIDTH(11),
                       .SUM_WIDTH(27), .COUNT_WIDTH(19), .MIN_PIXELS(1)) dut2 (
        .clk(clk), .aresetn(rst_n), .pixel_valid(pv2), .sof(sof2), .delta_frame(dlt2), .threshold(thr2),
        .x_position(xp2), .y_position(yp2), .x_min(xmn2), .x_max(xmx2), .y_min(ymn2), .y_max(ymx2),
        .pixel_count(pc2), .object_found(fnd2), .valid_position(vld2), .busy(bsy2), .overrun(ovr2));

    typedef struct {
        int x, y, xmin, xmax, ymin, ymax, cnt, found, cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    int checks = 0, errors = 0;
    int cyc = 0, last_acc = 0;
    int strobes2 = 0, cap_x2 = 0, cap_y2 = 0, cap_c2 = 0, cap_f2 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every strobe pops one expectation, including its arrival cycle
    always @(negedge clk) begin
        if (rst_n && vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got strobe at cycle %0d, expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("x_position", xp, e.x);
                chk("y_position", yp, e.y);
                chk("x_min", xmn, e.xmin);
                chk("x_max", xmx, e.xmax);
                chk("y_min", ymn, e.ymin);
                chk("y_max", ymx, e.ymax);
                chk("pixel_count", pc, e.cnt);
                chk("object_found", fnd, e.found);
                chk("latency_cycle", cyc, e.cyc);
                chk("busy_at_strobe", bsy, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && vld2) begin
            strobes2++;
            cap_x2 = int'(xp2); cap_y2 = int'(yp2); cap_c2 = int'(pc2); cap_f2 = int'(fnd2);
        end
    end

    task automatic drive(input logic v, input logic s, input int d);
        @(negedge clk);
        pv = v; sof = s; dlt = 10'(d);
        if (v) last_acc = cyc + 1;
    endtask

    task automatic drive2(input logic v, input logic s, input int d);
        @(negedge clk);
        pv2 = v; sof2 = s; dlt2 = 10'(d);
    endtask

    // Full raster frame; pixels inside [x0..x1]x[y0..y1] get inv, the rest outv
    task automatic run_frame(input int x0, x1, y0, y1, inv, outv, gap);
        for (int y = 0; y < FH; y++) begin
            for (int x = 0; x < FW; x++) begin
                while (gap > 0 && $urandom_range(99) < gap) drive(1'b0, 1'b0, 0);
                drive(1'b1, (x == 0 && y == 0),
                      (x >= x0 && x <= x1 && y >= y0 && y <= y1) ? inv : outv);
            end
        end
        drive(1'b0, 1'b0, 0);
    endtask

    task automatic expect_result(input int x, y, xmin, xmax, ymin, ymax, cnt, found);
        exp_t t;
        chk("busy_after_frame_end", bsy, 1);
        t.x = x; t.y = y; t.xmin = xmin; t.xmax = xmax; t.ymin = ymin; t.ymax = ymax;
        t.cnt = cnt; t.found = found; t.cyc = last_acc + LAT;
        exp_q.push_back(t);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_x_position", xp, 0);
        chk("reset_pixel_count", pc, 0);
        chk("reset_valid", vld, 0);
        chk("reset_busy", bsy, 0);
        chk("reset_overrun", ovr, 0);
        rst_n = 1'b1;

        // 10x10 object: sums 1450/950 over 100 pixels
        run_frame(10, 19, 5, 14, 1023, 0, 0);
        expect_result(14, 9, 10, 19, 5, 14, 100, 1);
        // Empty frame: count 0, position and box hold
        run_frame(1, 0, 1, 0, 0, 0, 0);
        expect_result(14, 9, 10, 19, 5, 14, 0, 0);
        // Threshold boundary: inside == threshold, outside == threshold-1
        thr = 10'd300;
        run_frame(2, 6, 3, 7, 300, 299, 0);
        expect_result(4, 5, 2, 6, 3, 7, 25, 1);
        run_frame(30, 32, 20, 22, 300, 299, 0);
        expect_result(4, 5, 2, 6, 3, 7, 9, 0);
        // Stalled stream, latency from last accepted pixel
        thr = 10'd512;
        run_frame(10, 19, 5, 14, 1023, 0, 50);
        expect_result(14, 9, 10, 19, 5, 14, 100, 1);
        // Partial frame of all-object pixels, restarted by sof at raster (20,10)
        for (int i = 0; i < 10 * FW + 20; i++) drive(1'b1, (i == 0), 1023);
        run_frame(10, 19, 5, 14, 1023, 0, 0);
        expect_result(14, 9, 10, 19, 5, 14, 100, 1);
        repeat (LAT + 5) drive(1'b0, 1'b0, 0);

        // Reset in the middle of the divide: no strobe, outputs cleared at once
        run_frame(2, 6, 3, 7, 1023, 0, 0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_x_position", xp, 0);
        chk("mid_reset_y_position", yp, 0);
        chk("mid_reset_x_max", xmx, 0);
        chk("mid_reset_pixel_count", pc, 0);
        chk("mid_reset_found", fnd, 0);
        chk("mid_reset_busy", bsy, 0);
        chk("mid_reset_valid", vld, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) drive(1'b0, 1'b0, 0);
        run_frame(10, 19, 5, 14, 1023, 0, 0);
        expect_result(14, 9, 10, 19, 5, 14, 100, 1);

        // Back-to-back 4x4 frames: second frame end lands while dividing
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 16; i++)
                drive2(1'b1, (i == 0), (f == 0 && i == 9) ? 1023 : 0);
        drive2(1'b0, 1'b0, 0);

        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: got %0d results pending, expected 0", exp_q.size());
        end
        repeat (20) @(negedge clk);
        chk("overrun_strobes", strobes2, 1);
        chk("overrun_first_x", cap_x2, 1);
        chk("overrun_first_y", cap_y2, 2);
        chk("overrun_first_count", cap_c2, 1);
        chk("overrun_first_found", cap_f2, 1);
        chk("overrun_flag", ovr2, 1);
        chk("overrun_busy_idle", bsy2, 0);
        chk("main_no_overrun", ovr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
